fp_mul_arbiter: RTL

- Shares one floating-point multiplier datapath (the `product` unit) among NUM_REQ requesters.
- Round-robin arbitration grants one requester at a time.
- Grantee's operands are registered and held stable on the multiplier inputs for MUL_LAT cycles.
- Result and classification status are captured and returned over a valid/ready response channel tagged with requester ID.
- Saturating event counters track overflow, underflow and special-value results for software visibility.

---
 rtl/fp_mul_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one floating-point multiplier among
// NUM_REQ requesters. The grantee's operands are registered onto the multiplier
// inputs, the result/status is captured after MUL_LAT cycles and returned on a
// valid/ready response channel tagged with the requester index. Saturating
// counters record overflow, underflow and special-value responses.
module fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [32*NUM_REQ-1:0]        req_a,
  input  logic [32*NUM_REQ-1:0]        req_b,
  output logic [31:0]                  mul_a,
  output logic [31:0]                  mul_b,
  input  logic [31:0]                  mul_result,
  input  logic [2:0]                   mul_status,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [31:0]                  rsp_data,
  output logic [2:0]                   rsp_status,
  input  logic                         clr_cnt,
  output logic [CNT_W-1:0]             cnt_ovf,
  output logic [CNT_W-1:0]             cnt_udf,
  output logic [CNT_W-1:0]             cnt_spc,
  output logic                         busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int LAT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [2:0] ST_PINF = 3'd2;
  localparam logic [2:0] ST_NINF = 3'd3;
  localparam logic [2:0] ST_NAN  = 3'd4;
  localparam logic [2:0] ST_OVF  = 3'd6;
  localparam logic [2:0] ST_UDF  = 3'd7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   op_id;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic [LAT_W-1:0]  lat_cnt;

  logic [ID_W-1:0]   gnt_id;
  logic              gnt_found;
  logic [ID_W-1:0]   scan_id;
  int                scan_idx;
  logic              rsp_hs;

  // Counters stop at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign mul_a  = op_a;
  assign mul_b  = op_b;
  assign busy   = (state != IDLE);
  assign rsp_hs = (state == DONE) && rsp_valid && rsp_ready;

  // Pick the first valid requester starting at rr_ptr; scanning downward lets
  // the entry closest to rr_ptr be the last (winning) assignment.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_idx  = 0;
    scan_id   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      scan_id = ID_W'(scan_idx);
      if (req_valid[scan_id]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_id;
      end
    end
  end

  // Grant is combinational and only offered while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && rst_n && gnt_found) req_ready[gnt_id] = 1'b1;
  end

  // Control FSM: latch operands on grant, wait MUL_LAT cycles, hold response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      op_id      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      lat_cnt    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_status <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            op_a    <= req_a[{gnt_id, 5'b0} +: 32];
            op_b    <= req_b[{gnt_id, 5'b0} +: 32];
            op_id   <= gnt_id;
            rr_ptr  <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            lat_cnt <= LAT_W'(MUL_LAT - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (lat_cnt == '0) begin
            rsp_data   <= mul_result;
            rsp_status <= mul_status;
            rsp_id     <= op_id;
            rsp_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Event counters advance only when a response is actually delivered; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ovf <= '0;
      cnt_udf <= '0;
      cnt_spc <= '0;
    end else if (clr_cnt) begin
      cnt_ovf <= '0;
      cnt_udf <= '0;
      cnt_spc <= '0;
    end else if (rsp_hs) begin
      case (rsp_status)
        ST_OVF:                  cnt_ovf <= sat_inc(cnt_ovf);
        ST_UDF:                  cnt_udf <= sat_inc(cnt_udf);
        ST_PINF, ST_NINF, ST_NAN: cnt_spc <= sat_inc(cnt_spc);
        default: ;
      endcase
    end
  end

endmodule
